// File: rtl/if_ctrl_pkg.sv
// Shared encodings and defaults for the fetch-stage controller.
// Optional IF_CTRL_PERF_EN adds performance counters to if_ctrl.
package if_ctrl_pkg;

  localparam int MEM_DEPTH_DEF    = 18;
  localparam int ADDR_W_DEF       = 6;
  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int DRAIN_W          = $clog2(DRAIN_CYCLES_DEF) + 1;
  localparam int PERF_W           = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_HALT  = 3'd4;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    if (en && (v != {PERF_W{1'b1}})) begin
      return v + 16'd1;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/if_ctrl_loader.sv
// Program-load write port: word address counter plus valid/ready handshake
// into the instruction memory.
module if_ctrl_loader
  import if_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              active_i,
  input  logic              clear_i,
  input  logic              load_valid_i,
  input  logic [31:0]       load_data_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_waddr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              xfer_s;

  assign xfer_s       = active_i & load_valid_i;
  assign load_ready_o = active_i;
  assign imem_we_o    = xfer_s;
  assign imem_waddr_o = addr_q;
  assign imem_wdata_o = xfer_s ? load_data_i : 32'h0000_0000;
  // Stopping at the last word keeps the counter from wrapping onto loaded code.
  assign done_o       = xfer_s & (load_last_i | (addr_q == LAST_ADDR));

  // Next write address
  always_comb begin
    addr_d = addr_q;
    if (clear_i) begin
      addr_d = '0;
    end else if (xfer_s) begin
      addr_d = addr_q + ADDR_W'(1);
    end else begin
      addr_d = addr_q;
    end
  end

  // Address register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/if_ctrl.sv
// Fetch-stage controller: program load, PC/IF-ID gating, flushes, halt drain.
// Define IF_CTRL_PERF_EN to add stall/flush/fetch counters.
module if_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH    = MEM_DEPTH_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              load_req,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  input  logic              PCSrc,
  input  logic              hazard_stall,
  input  logic              halt_req,
  output logic              pc_write,
  output logic              pc_clear,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              running,
  output logic              halted
`ifdef IF_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_count,
  output logic [PERF_W-1:0] flush_count,
  output logic [PERF_W-1:0] fetch_count
`endif
);

  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               ld_clear_s, ld_done_s;

  if_ctrl_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) u_loader (
    .clock        (clock),
    .reset        (reset),
    .active_i     (state_q == ST_LOAD),
    .clear_i      (ld_clear_s),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .load_last_i  (load_last),
    .load_ready_o (load_ready),
    .imem_we_o    (imem_we),
    .imem_waddr_o (imem_waddr),
    .imem_wdata_o (imem_wdata),
    .done_o       (ld_done_s)
  );

  // Output decode and next state; RUN priority is PCSrc > stall > halt
  always_comb begin
    state_d      = state_q;
    drain_d      = drain_q;
    ld_clear_s   = 1'b0;
    pc_write     = 1'b0;
    pc_clear     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    running      = 1'b0;
    halted       = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        halted = (state_q == ST_HALT);
        if (load_req) begin
          state_d    = ST_LOAD;
          ld_clear_s = 1'b1;
        end else if (start) begin
          state_d  = ST_RUN;
          pc_clear = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (ld_done_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        running = 1'b1;
        if (PCSrc) begin
          pc_write     = 1'b1;
          if_id_write  = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
        end else if (hazard_stall) begin
          id_ex_flush = 1'b1;
        end else if (halt_req) begin
          if_id_flush = 1'b1;
          state_d     = ST_DRAIN;
          drain_d     = DRAIN_INIT;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      ST_DRAIN: begin
        if_id_flush = 1'b1;
        if (drain_q == '0) begin
          state_d = ST_HALT;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and drain counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

`ifdef IF_CTRL_PERF_EN
  // Saturating performance counters, restarted whenever execution starts
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
      fetch_count <= '0;
    end else if (pc_clear) begin
      stall_count <= '0;
      flush_count <= '0;
      fetch_count <= '0;
    end else begin
      stall_count <= sat_inc(stall_count, running & hazard_stall & ~PCSrc);
      flush_count <= sat_inc(flush_count, running & PCSrc);
      fetch_count <= sat_inc(fetch_count, running & pc_write);
    end
  end
`endif

endmodule

// File: tb/tb_if_ctrl.sv
// Scoreboard bench for if_ctrl: the driver queues expected outputs per cycle,
// a negedge monitor pops and compares.
module tb_if_ctrl;

  logic        clock = 1'b0;
  logic        reset, start, load_req, load_valid, load_last;
  logic [31:0] load_data;
  logic        PCSrc, hazard_stall, halt_req;
  logic        load_ready, imem_we, pc_write, pc_clear, if_id_write;
  logic        if_id_flush, id_ex_flush, ex_mem_flush, running, halted;
  logic [5:0]  imem_waddr;
  logic [31:0] imem_wdata;
`ifdef IF_CTRL_PERF_EN
  logic [15:0] stall_count, flush_count, fetch_count;
`endif

  if_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .load_req(load_req),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .PCSrc(PCSrc), .hazard_stall(hazard_stall),
    .halt_req(halt_req), .pc_write(pc_write), .pc_clear(pc_clear),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .running(running), .halted(halted)
`ifdef IF_CTRL_PERF_EN
    , .stall_count(stall_count), .flush_count(flush_count), .fetch_count(fetch_count)
`endif
  );

  always #5 clock = ~clock;

  localparam logic [9:0] LRDY = 10'b10_0000_0000;
  localparam logic [9:0] WE   = 10'b01_0000_0000;
  localparam logic [9:0] PCW  = 10'b00_1000_0000;
  localparam logic [9:0] PCC  = 10'b00_0100_0000;
  localparam logic [9:0] IFW  = 10'b00_0010_0000;
  localparam logic [9:0] IFF  = 10'b00_0001_0000;
  localparam logic [9:0] IDF  = 10'b00_0000_1000;
  localparam logic [9:0] EXF  = 10'b00_0000_0100;
  localparam logic [9:0] RUN  = 10'b00_0000_0010;
  localparam logic [9:0] HLT  = 10'b00_0000_0001;
  localparam logic [9:0] NONE = 10'b00_0000_0000;

  typedef struct packed {
    logic [9:0]  f;
    logic [5:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [9:0] act;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic logic [9:0] outs();
    return {load_ready, imem_we, pc_write, pc_clear, if_id_write,
            if_id_flush, id_ex_flush, ex_mem_flush, running, halted};
  endfunction

  // Monitor: one queued expectation per cycle, checked mid-cycle
  always @(negedge clock) begin
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = outs();
      vectors++;
      if (act !== e.f) begin
        miscompares++;
        $display("FAIL ctl t=%0t actual=%b required=%b", $time, act, e.f);
      end
      if (e.f[8]) begin
        vectors++;
        if (imem_waddr !== e.addr || imem_wdata !== e.data) begin
          miscompares++;
          $display("FAIL imem t=%0t actual=%0d/%h required=%0d/%h",
                   $time, imem_waddr, imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic cyc(input logic [9:0] f, input logic [5:0] a = 6'd0,
                     input logic [31:0] d = 32'h0);
    exp_t x;
    x.f = f; x.addr = a; x.data = d;
    sb.push_back(x);
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] r);
    vectors++;
    if (a !== r) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, a, r);
    end
  endtask

  logic [31:0] words [3];

  initial begin
    words[0] = 32'h2008_0005; words[1] = 32'h2009_0003; words[2] = 32'h0109_5020;
    reset = 1'b1; start = 1'b0; load_req = 1'b0; load_valid = 1'b0;
    load_last = 1'b0; load_data = 32'h0; PCSrc = 1'b0; hazard_stall = 1'b0;
    halt_req = 1'b0;
    @(posedge clock); #1;
    cyc(NONE);                              // reset state
    reset = 1'b0;
    cyc(NONE);

    // three-word load with load_last, including one idle beat
    load_req = 1'b1; cyc(NONE);
    load_req = 1'b0; cyc(LRDY);
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = words[i]; load_last = (i == 2);
      cyc(LRDY | WE, 6'(i), words[i]);
    end
    load_last = 1'b0; load_data = 32'hDEAD_BEEF;
    cyc(NONE);                              // back in IDLE, load ignored
    load_valid = 1'b0;
    cyc(NONE);

    // 20 words offered, only 18 written
    load_req = 1'b1; cyc(NONE);
    load_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      load_valid = 1'b1; load_data = 32'hA000_0000 + 32'(i);
      if (i < 18) cyc(LRDY | WE, 6'(i), load_data);
      else        cyc(NONE);
    end
    load_valid = 1'b0;

    // reset mid-load: write enable drops without a clock edge
    load_req = 1'b1; cyc(NONE);
    load_req = 1'b0; load_valid = 1'b1; load_data = 32'h1111_2222;
    #1 chk("we_before_reset", {31'd0, imem_we}, 32'd1);
    reset = 1'b1;
    #1 chk("we_async_drop", {22'd0, outs()}, 32'd0);
    @(posedge clock); #1;
    load_valid = 1'b0;
    cyc(NONE);
    reset = 1'b0;
    load_req = 1'b1; cyc(NONE);
    load_req = 1'b0; load_valid = 1'b1; load_last = 1'b1; load_data = 32'h3333_4444;
    cyc(LRDY | WE, 6'd0, 32'h3333_4444);    // counter restarted at 0
    load_valid = 1'b0; load_last = 1'b0;
    cyc(NONE);

    // start and five normal fetch cycles
    start = 1'b1; cyc(PCC);
    start = 1'b0;
    repeat (5) cyc(RUN | PCW | IFW);

    // branch squashes a simultaneous stall
    PCSrc = 1'b1; hazard_stall = 1'b1; cyc(RUN | PCW | IFW | IFF | IDF | EXF);
    PCSrc = 1'b0;
    repeat (2) cyc(RUN | IDF);              // two-cycle load-use stall
    hazard_stall = 1'b0;
    cyc(RUN | PCW | IFW);
`ifdef IF_CTRL_PERF_EN
    chk("stall_count", {16'd0, stall_count}, 32'd2);
    chk("flush_count", {16'd0, flush_count}, 32'd1);
    chk("fetch_count", {16'd0, fetch_count}, 32'd7);
`endif

    // halt with start ignored, branch/stall ignored in drain, halted after 5 edges
    halt_req = 1'b1; start = 1'b1; cyc(RUN | IFF);
    halt_req = 1'b0; start = 1'b0;
    PCSrc = 1'b1; hazard_stall = 1'b1; cyc(IFF);
    PCSrc = 1'b0; hazard_stall = 1'b0;
    repeat (3) cyc(IFF);
    cyc(HLT);
    cyc(HLT);
    start = 1'b1; cyc(HLT | PCC);
    start = 1'b0; cyc(RUN | PCW | IFW);

    // reset during drain
    halt_req = 1'b1; cyc(RUN | IFF);
    halt_req = 1'b0; cyc(IFF);
    reset = 1'b1;
    #1 chk("drain_async_reset", {22'd0, outs()}, 32'd0);
    @(posedge clock); #1;
    cyc(NONE);
    reset = 1'b0;
    cyc(NONE);                              // IDLE, halted low
    start = 1'b1; cyc(PCC);
    start = 1'b0; cyc(RUN | PCW | IFW);

    @(negedge clock); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_ctrl.md
# if_ctrl

Fetch-stage controller for the 5-stage MIPS pipeline. Sequences the instruction-fetch datapath: owns the instruction-memory write port during program load, then gates PC update, IF/ID write and pipeline flushes during execution, and drains the pipeline on a halt request. Sits beside the IF stage; its outputs drive the PC enable/clear, the IF/ID register enable/flush, the ID/EX and EX/MEM flushes and the imem write port.

## Interface
- MEM_DEPTH, 18: instruction memory depth in 32-bit words
- ADDR_W, 6: imem word-address width (PC[7:2])
- DRAIN_CYCLES, 4: bubble cycles inserted after halt_req before halted
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; one clock, reset is asynchronous and active-high
- start  in  1  leave IDLE and begin fetching from PC 0
- load_req  in  1  request program load (honoured in IDLE/HALT only)
- load_valid  in  1  load_data valid
- load_data  in  32  instruction word to write
- load_last  in  1  qualifies final word of load
- load_ready  out  1  controller accepts a load word this cycle
- imem_we  out  1  imem write enable
- imem_waddr  out  ADDR_W  imem word write address
- imem_wdata  out  32  imem write data
- PCSrc  in  1  branch taken, resolved in MEM
- hazard_stall  in  1  load-use hazard from ID
- halt_req  in  1  halt instruction decoded in ID
- pc_write  out  1  PC register enable
- pc_clear  out  1  force PC to 0 next edge
- if_id_write  out  1  IF/ID register enable
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  insert bubble into that register
- running, halted  out  1 each  status

## Operation
- States: IDLE, LOAD, RUN, DRAIN, HALT. Reset -> IDLE; every output 0, address counter 0, drain counter 0.
- IDLE: load_req -> LOAD (counter cleared); else start -> RUN with pc_clear=1 that cycle. load_req wins if both.
- LOAD: load_ready=1. Transfer = load_valid && load_ready: imem_we=1, imem_waddr=counter, imem_wdata=load_data (combinational pass-through), counter++. Transfer with load_last, or at counter==MEM_DEPTH-1 -> IDLE. Words beyond MEM_DEPTH never written. pc_write=0 throughout.
- RUN: running=1. Priority PCSrc > hazard_stall > halt_req > normal.
  - normal: pc_write=1, if_id_write=1.
  - PCSrc: pc_write=1 (target loaded), if_id_flush=id_ex_flush=ex_mem_flush=1, if_id_write=1; hazard_stall and halt_req ignored that cycle (squashed).
  - hazard_stall: pc_write=0, if_id_write=0, id_ex_flush=1.
  - halt_req: pc_write=0, if_id_flush=1, -> DRAIN, drain counter=DRAIN_CYCLES-1.
- DRAIN: pc_write=0, if_id_flush=1; PCSrc and hazard_stall ignored; counter decrements; at 0 -> HALT.
- HALT: halted=1, all enables 0. load_req -> LOAD; start -> RUN with pc_clear=1.
- load_* ignored outside LOAD; start ignored outside IDLE/HALT.

## Timing
- Control outputs are combinational decodes of registered state plus same-cycle PCSrc/hazard_stall/halt_req; effect lands at the next rising edge.
- Load throughput 1 word/cycle; first word may arrive the cycle after load_req is sampled.
- halt_req at edge N -> DRAIN from N+1 -> halted high after exactly DRAIN_CYCLES+1 edges.
- reset mid-LOAD or mid-DRAIN: immediate return to IDLE, partial imem contents left as-is, imem_we drops asynchronously.

## Configuration
- IF_CTRL_PERF_EN defined: adds 16-bit saturating outputs stall_count (RUN cycles with hazard_stall and no PCSrc), flush_count (RUN cycles with PCSrc), fetch_count (pc_write cycles in RUN); cleared by reset and on start.
- Undefined: ports and counters absent; no other change.

## Structure
- Shared package: state encoding typedef, MEM_DEPTH/ADDR_W/DRAIN_CYCLES defaults, counter width constant.
- One sub-module: if_ctrl_loader (LOAD address counter + handshake), instantiated once.

## Test plan
- Load 3 words 0x20080005, 0x20090003, 0x01095020 with load_last on third -> imem_waddr 0,1,2, imem_we 3 cycles, return to IDLE, pc_write stays 0.
- Load 20 words without load_last -> exactly 18 writes (addr 0..17), IDLE after addr 17.
- start then 5 RUN cycles -> pc_clear 1 cycle, pc_write/if_id_write high 5 cycles.
- hazard_stall 1 cycle with PCSrc 1 same cycle -> all three flushes high, pc_write=1, no id_ex-only stall pattern.
- hazard_stall 2 cycles -> pc_write=0, if_id_write=0, id_ex_flush=1 for 2 cycles; with PERF stall_count=2.
- halt_req in RUN, PCSrc pulsed during DRAIN -> halted after 5 edges, PCSrc ignored; reset during DRAIN -> IDLE, halted=0.
